// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  // Nine's complement of one BCD digit, wrapping modulo 16 for invalid digits.
  function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
    return DIGIT_W'(4'd9 - d);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit add with +6 correction; combinational.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic [DIGIT_W:0] t;

  // Binary sum, then decimal correction truncated back to one digit.
  always_comb begin
    t = (DIGIT_W+1)'(a) + (DIGIT_W+1)'(b) + (DIGIT_W+1)'(ci);
    if (t > (DIGIT_W+1)'(BCD_MAX)) begin
      s  = DIGIT_W'(t + (DIGIT_W+1)'(BCD_CORR));
      co = 1'b1;
    end else begin
      s  = t[DIGIT_W-1:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_adder_serial.sv
// Digit-serial packed-BCD adder/subtractor with start/busy/done handshake.
module bcd_adder_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        sub,
  input  logic                        cin,
  input  logic [DIGIT_W*DIGITS-1:0]   a,
  input  logic [DIGIT_W*DIGITS-1:0]   b,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   sum,
  output logic                        cout,
  output logic                        err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, res_q, res_next;
  logic               sub_q, carry_q, err_q;
  logic [IDX_W-1:0]   idx_q;
  logic               capture, last;
  logic               err_in;
  logic [DIGIT_W-1:0] bd, s;
  logic               co;

  // Flag any operand digit above 9 at capture time.
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX) ||
          b[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX))
        err_in = 1'b1;
    end
  end

  // Current digit of B, complemented for subtraction.
  always_comb begin
    bd       = sub_q ? nines(b_q[DIGIT_W-1:0]) : b_q[DIGIT_W-1:0];
    res_next = W'({s, res_q} >> DIGIT_W);
  end

  bcd_digit_add u_digit (
    .a  (a_q[DIGIT_W-1:0]),
    .b  (bd),
    .ci (carry_q),
    .s  (s),
    .co (co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and operand capture strobe.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    last    = (idx_q == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          capture = 1'b1;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          capture = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  // Working shift registers and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        a_q     <= a;
        b_q     <= b;
        sub_q   <= sub;
        carry_q <= sub ? ~cin : cin;
        err_q   <= err_in;
        idx_q   <= '0;
        res_q   <= '0;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> DIGIT_W;
        b_q     <= b_q >> DIGIT_W;
        carry_q <= co;
        res_q   <= res_next;
        idx_q   <= idx_q + IDX_W'(1);
        if (last) begin
          done <= 1'b1;
          sum  <= res_next;
          cout <= co;
          err  <= err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Directed self-checking bench for bcd_adder_serial (DIGITS=4).
module tb_bcd_adder_serial;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst, start, sub, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  bcd_adder_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait for done; reports latency, busy cycles, sum stability.
  task automatic run_op(input logic s_i, input logic c_i, input logic [15:0] a_i,
                        input logic [15:0] b_i, output int lat, output int bcnt,
                        output logic stable);
    logic [15:0] held;
    logic        got;
    @(negedge clk);
    sub = s_i; cin = c_i; a = a_i; b = b_i; start = 1'b1;
    held = sum;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = ~s_i; cin = ~c_i;
    lat = 0; bcnt = 0; got = 1'b0; stable = 1'b1;
    while (!got && lat < 20) begin
      if (busy) bcnt++;
      if (sum !== held) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
    end
  endtask

  initial begin
    int   lat, bcnt, gap;
    logic stable, seen;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h9999, 16'h9999, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h12A4, 16'h0001, 16'h1305, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 16'h1000, 16'h0001, 16'h0998, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_err",  32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, lat, bcnt, stable);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(DIGITS));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(DIGITS));
      chk($sformatf("v%0d_sum_stable", i), 32'(stable), 32'd1);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start held through RUN is ignored, then accepted in DONE with no gap.
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    sub = 1'b1; a = 16'h5000; b = 16'h1234;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    chk("hold_first_latency", 32'(lat), 32'(DIGITS));
    chk("hold_first_sum", 32'(sum), 32'h6912);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_no_gap", 32'(busy), 32'd1);
    gap = 1; seen = 1'b0; stable = 1'b1;
    while (!seen && gap < 20) begin
      if (sum !== 16'h6912) stable = 1'b0;
      @(posedge clk); #1;
      gap++;
      if (done) seen = 1'b1;
    end
    chk("b2b_done_spacing", 32'(gap), 32'(DIGITS + 1));
    chk("b2b_old_sum_held", 32'(stable), 32'd1);
    chk("b2b_second_sum", 32'(sum), 32'h3766);
    chk("b2b_second_cout", 32'(cout), 32'd1);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_err",  32'(err),  32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(1'b0, 1'b1, 16'h4567, 16'h4444, lat, bcnt, stable);
    chk("fresh_latency", 32'(lat), 32'(DIGITS));
    chk("fresh_sum", 32'(sum), 32'h9012);
    chk("fresh_cout", 32'(cout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
